// File: rtl/hazard_if.sv
// Hazard-unit bus: pipeline register-address/control taps in, forward/stall/flush controls out.
// The pipeline side drives through master; hazard_unit receives through slave.
interface hazard_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] rs_D, rt_D, rs_E, rt_E;
  logic [REG_W-1:0] writeReg_E, writeReg_M, writeReg_W;
  logic             branch_D, jr_D, jump_D, pcSrc_D;
  logic             regWrite_E, memToReg_E;
  logic             regWrite_M, memToReg_M, memAccess_M;
  logic             regWrite_W;
  logic             fwdA_D, fwdB_D;
  logic [1:0]       fwdA_E, fwdB_E;
  logic             stall_F, stall_D, stall_E, stall_M;
  logic             flush_D, flush_E, mem_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output rs_D, rt_D, rs_E, rt_E, writeReg_E, writeReg_M, writeReg_W,
           branch_D, jr_D, jump_D, pcSrc_D, regWrite_E, memToReg_E,
           regWrite_M, memToReg_M, memAccess_M, regWrite_W,
    input  fwdA_D, fwdB_D, fwdA_E, fwdB_E, stall_F, stall_D, stall_E, stall_M,
           flush_D, flush_E, mem_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs_D, rt_D, rs_E, rt_E, writeReg_E, writeReg_M, writeReg_W,
           branch_D, jr_D, jump_D, pcSrc_D, regWrite_E, memToReg_E,
           regWrite_M, memToReg_M, memAccess_M, regWrite_W,
    output fwdA_D, fwdB_D, fwdA_E, fwdB_E, stall_F, stall_D, stall_E, stall_M,
           flush_D, flush_E, mem_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// 5-stage pipeline hazard/forwarding controller with a data-memory wait FSM
// that freezes the pipeline, plus saturating stall/flush statistics.
module hazard_unit #(
  parameter int REG_W   = 5,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32,
  parameter int FWD_EN  = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);
  localparam int LAT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e           state_q, state_d;
  logic [LAT_W-1:0] wait_q, wait_d;
  logic             rel_q, rel_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic       lw_stall, br_stall, raw_stall, hz_stall, freeze;
  logic       fa_d, fb_d, st_f, st_e, fl_d, fl_e;
  logic [1:0] fa_e, fb_e;

  function automatic logic nz_eq(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  // Branch compares both operands; jr only reads rs.
  function automatic logic br_op(input logic [REG_W-1:0] r, input logic [REG_W-1:0] rs,
                                 input logic [REG_W-1:0] rt, input logic is_br);
    return nz_eq(r, rs) || (is_br && nz_eq(r, rt));
  endfunction

  assign freeze = (state_q == S_WAIT);

  always_comb begin
    lw_stall  = hz.memToReg_E &&
                (nz_eq(hz.writeReg_E, hz.rs_D) || nz_eq(hz.writeReg_E, hz.rt_D));
    br_stall  = (hz.branch_D || hz.jr_D) &&
                ((hz.regWrite_E && br_op(hz.writeReg_E, hz.rs_D, hz.rt_D, hz.branch_D)) ||
                 (hz.memToReg_M && br_op(hz.writeReg_M, hz.rs_D, hz.rt_D, hz.branch_D)));
    raw_stall = (hz.regWrite_E && (nz_eq(hz.writeReg_E, hz.rs_D) || nz_eq(hz.writeReg_E, hz.rt_D))) ||
                (hz.regWrite_M && (nz_eq(hz.writeReg_M, hz.rs_D) || nz_eq(hz.writeReg_M, hz.rt_D))) ||
                (hz.regWrite_W && (nz_eq(hz.writeReg_W, hz.rs_D) || nz_eq(hz.writeReg_W, hz.rt_D)));
    hz_stall  = (FWD_EN != 0) ? (lw_stall || br_stall) : raw_stall;
  end

  always_comb begin
    fa_e = 2'b00;
    fb_e = 2'b00;
    fa_d = 1'b0;
    fb_d = 1'b0;
    if (FWD_EN != 0) begin
      if (hz.regWrite_M && nz_eq(hz.writeReg_M, hz.rs_E))      fa_e = 2'b10;
      else if (hz.regWrite_W && nz_eq(hz.writeReg_W, hz.rs_E)) fa_e = 2'b01;
      if (hz.regWrite_M && nz_eq(hz.writeReg_M, hz.rt_E))      fb_e = 2'b10;
      else if (hz.regWrite_W && nz_eq(hz.writeReg_W, hz.rt_E)) fb_e = 2'b01;
      fa_d = hz.regWrite_M && !hz.memToReg_M && nz_eq(hz.writeReg_M, hz.rs_D);
      fb_d = hz.regWrite_M && !hz.memToReg_M && nz_eq(hz.writeReg_M, hz.rt_D);
    end
  end

  // Freeze beats hazard stall beats flush; everything reads 0 while reset is held.
  always_comb begin
    st_f = 1'b0;
    st_e = 1'b0;
    fl_d = 1'b0;
    fl_e = 1'b0;
    if (rst_n) begin
      st_f = freeze || hz_stall;
      st_e = freeze;
      fl_e = hz_stall && !freeze;
      fl_d = (hz.pcSrc_D || hz.jump_D) && !st_f && !freeze;
    end
  end

  assign hz.fwdA_E    = rst_n ? fa_e : 2'b00;
  assign hz.fwdB_E    = rst_n ? fb_e : 2'b00;
  assign hz.fwdA_D    = rst_n && fa_d;
  assign hz.fwdB_D    = rst_n && fb_d;
  assign hz.stall_F   = st_f;
  assign hz.stall_D   = st_f;
  assign hz.stall_E   = st_e;
  assign hz.stall_M   = st_e;
  assign hz.flush_D   = fl_d;
  assign hz.flush_E   = fl_e;
  assign hz.mem_busy  = rst_n && freeze;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

  // rel_q masks the released access, which is still sitting in MEM for one cycle.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    rel_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((MEM_LAT > 1) && hz.memAccess_M && !rel_q) begin
          state_d = S_WAIT;
          wait_d  = LAT_W'(MEM_LAT - 1);
        end
      end
      S_WAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q == LAT_W'(1)) begin
          state_d = S_IDLE;
          rel_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      rel_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rel_q   <= rel_d;
      if (st_f && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if ((fl_d || fl_e) && !(&flush_cnt_q))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// Directed scenarios plus a randomized run checked against a spec-level model.
module tb_hazard_unit;
  localparam int REG_W   = 5;
  localparam int MEM_LAT = 3;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  hazard_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hif();

  hazard_unit #(.REG_W(REG_W), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W), .FWD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    hif.rs_D = '0; hif.rt_D = '0; hif.rs_E = '0; hif.rt_E = '0;
    hif.writeReg_E = '0; hif.writeReg_M = '0; hif.writeReg_W = '0;
    hif.branch_D = 0; hif.jr_D = 0; hif.jump_D = 0; hif.pcSrc_D = 0;
    hif.regWrite_E = 0; hif.memToReg_E = 0; hif.regWrite_M = 0;
    hif.memToReg_M = 0; hif.memAccess_M = 0; hif.regWrite_W = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_lw_hazard();
    hif.regWrite_E = 1; hif.memToReg_E = 1; hif.writeReg_E = 5'd8;
    hif.rs_D = 5'd8; hif.rt_D = 5'd10;
  endtask

  // Reference model state for the random phase.
  int m_sc, m_fc, m_left;
  bit m_ign;

  function automatic bit in_ops(input logic [4:0] r);
    return (r != 0) && (r == hif.rs_D || (hif.branch_D && r == hif.rt_D));
  endfunction

  function automatic int fwd_e(input logic [4:0] src);
    if (hif.regWrite_M && hif.writeReg_M != 0 && hif.writeReg_M == src) return 2;
    if (hif.regWrite_W && hif.writeReg_W != 0 && hif.writeReg_W == src) return 1;
    return 0;
  endfunction

  initial begin
    bit busy, lw, br, hzd, sf, fe, fd;
    int ea_d, eb_d;

    // Reset: outputs are 0 even with a live forwarding/stall pattern.
    clr();
    set_lw_hazard();
    hif.regWrite_M = 1; hif.writeReg_M = 5'd8; hif.rs_E = 5'd8; hif.pcSrc_D = 1;
    #3;
    chk("rst_fwdA_E", hif.fwdA_E, 0);
    chk("rst_stall_F", hif.stall_F, 0);
    chk("rst_flush_D", hif.flush_D, 0);
    chk("rst_stall_cnt", hif.stall_cnt, 0);
    chk("rst_mem_busy", hif.mem_busy, 0);
    tick();
    rst_n = 1'b1;

    // Forwarding priority and $zero.
    clr();
    hif.rs_E = 5'd8; hif.rt_E = 5'd8; hif.regWrite_M = 1; hif.writeReg_M = 5'd8;
    hif.regWrite_W = 1; hif.writeReg_W = 5'd8;
    #2;
    chk("fwd_mem_A", hif.fwdA_E, 2);
    chk("fwd_mem_B", hif.fwdB_E, 2);
    hif.regWrite_M = 0;
    #2;
    chk("fwd_wb_A", hif.fwdA_E, 1);
    hif.rs_E = 5'd0; hif.regWrite_M = 1; hif.writeReg_M = 5'd0;
    hif.writeReg_W = 5'd0;
    #2;
    chk("fwd_zero", hif.fwdA_E, 0);
    tick();

    // Load-use stall.
    pulse_reset();
    clr();
    set_lw_hazard();
    #2;
    chk("lw_stall_F", hif.stall_F, 1);
    chk("lw_stall_D", hif.stall_D, 1);
    chk("lw_flush_E", hif.flush_E, 1);
    chk("lw_stall_E", hif.stall_E, 0);
    tick();
    clr();
    hif.rs_E = 5'd8; hif.regWrite_W = 1; hif.writeReg_W = 5'd8;
    #2;
    chk("lw_after_fwdA_E", hif.fwdA_E, 1);
    chk("lw_after_stall_F", hif.stall_F, 0);
    chk("lw_stall_cnt", hif.stall_cnt, 1);
    tick();

    // Branch-operand stall, then ID forwarding and the taken-branch flush.
    pulse_reset();
    clr();
    hif.regWrite_E = 1; hif.writeReg_E = 5'd9; hif.branch_D = 1;
    hif.rs_D = 5'd9; hif.rt_D = 5'd10; hif.pcSrc_D = 1;
    #2;
    chk("br_stall_F", hif.stall_F, 1);
    chk("br_flush_E", hif.flush_E, 1);
    chk("br_flush_D_blocked", hif.flush_D, 0);
    tick();
    hif.regWrite_E = 0; hif.regWrite_M = 1; hif.writeReg_M = 5'd9;
    #2;
    chk("br_fwdA_D", hif.fwdA_D, 1);
    chk("br_fwdB_D", hif.fwdB_D, 0);
    chk("br_flush_D", hif.flush_D, 1);
    tick();
    clr();
    #2;
    chk("br_flush_cnt", hif.flush_cnt, 2);
    tick();

    // Memory freeze, masked release, back-to-back access.
    pulse_reset();
    clr();
    hif.memAccess_M = 1;
    #2;
    chk("mem_A_busy", hif.mem_busy, 0);
    chk("mem_A_stall_F", hif.stall_F, 0);
    tick();
    hif.pcSrc_D = 1;
    set_lw_hazard();
    for (int k = 0; k < 2; k++) begin
      #2;
      chk("mem_wait_busy", hif.mem_busy, 1);
      chk("mem_wait_stall_F", hif.stall_F, 1);
      chk("mem_wait_stall_M", hif.stall_M, 1);
      chk("mem_wait_flush_D", hif.flush_D, 0);
      chk("mem_wait_flush_E", hif.flush_E, 0);
      tick();
    end
    hif.regWrite_E = 0; hif.memToReg_E = 0;
    #2;
    chk("mem_rel_busy", hif.mem_busy, 0);
    chk("mem_rel_flush_D", hif.flush_D, 1);
    chk("mem_rel_stall_cnt", hif.stall_cnt, 2);
    tick();
    hif.pcSrc_D = 0;
    #2;
    chk("mem_next_busy", hif.mem_busy, 0);
    tick();
    hif.memAccess_M = 0;
    #2;
    chk("mem_b2b_busy", hif.mem_busy, 1);
    tick();
    tick();
    #2;
    chk("mem_b2b_done", hif.mem_busy, 0);
    tick();

    // Reset mid-WAIT takes effect with no clock edge.
    pulse_reset();
    clr();
    hif.memAccess_M = 1;
    tick();
    hif.memAccess_M = 0;
    tick();
    #2;
    chk("rw_busy_before", hif.mem_busy, 1);
    chk("rw_cnt_before", hif.stall_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk("rw_busy_async", hif.mem_busy, 0);
    chk("rw_stall_async", hif.stall_F, 0);
    chk("rw_cnt_async", hif.stall_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Counter saturation.
    pulse_reset();
    clr();
    set_lw_hazard();
    repeat (20) tick();
    #2;
    chk("sat_stall_cnt", hif.stall_cnt, CMAX);
    chk("sat_flush_cnt", hif.flush_cnt, CMAX);
    tick();
    tick();
    chk("sat_stall_hold", hif.stall_cnt, CMAX);
    clr();
    tick();

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) begin
        pulse_reset();
        m_sc = 0; m_fc = 0; m_left = 0; m_ign = 0;
      end
      hif.rs_D = 5'($urandom_range(0, 3)); hif.rt_D = 5'($urandom_range(0, 3));
      hif.rs_E = 5'($urandom_range(0, 3)); hif.rt_E = 5'($urandom_range(0, 3));
      hif.writeReg_E = 5'($urandom_range(0, 3));
      hif.writeReg_M = 5'($urandom_range(0, 3));
      hif.writeReg_W = 5'($urandom_range(0, 3));
      hif.branch_D = 1'($urandom); hif.jr_D = ($urandom_range(0, 3) == 0);
      hif.jump_D = ($urandom_range(0, 3) == 0); hif.pcSrc_D = 1'($urandom);
      hif.regWrite_E = 1'($urandom); hif.memToReg_E = 1'($urandom);
      hif.regWrite_M = 1'($urandom); hif.memToReg_M = 1'($urandom);
      hif.regWrite_W = 1'($urandom);
      hif.memAccess_M = ($urandom_range(0, 4) == 0);
      #2;
      busy = (m_left > 0);
      lw  = hif.memToReg_E && hif.writeReg_E != 0 &&
            (hif.writeReg_E == hif.rs_D || hif.writeReg_E == hif.rt_D);
      br  = (hif.branch_D || hif.jr_D) &&
            ((hif.regWrite_E && in_ops(hif.writeReg_E)) || (hif.memToReg_M && in_ops(hif.writeReg_M)));
      hzd = lw || br;
      sf  = busy || hzd;
      fe  = hzd && !busy;
      fd  = (hif.pcSrc_D || hif.jump_D) && !sf;
      ea_d = (hif.regWrite_M && !hif.memToReg_M && hif.writeReg_M != 0 && hif.writeReg_M == hif.rs_D);
      eb_d = (hif.regWrite_M && !hif.memToReg_M && hif.writeReg_M != 0 && hif.writeReg_M == hif.rt_D);
      chk("rnd_fwdA_E", hif.fwdA_E, fwd_e(hif.rs_E));
      chk("rnd_fwdB_E", hif.fwdB_E, fwd_e(hif.rt_E));
      chk("rnd_fwdA_D", hif.fwdA_D, ea_d);
      chk("rnd_fwdB_D", hif.fwdB_D, eb_d);
      chk("rnd_stall_D", hif.stall_D, sf);
      chk("rnd_stall_E", hif.stall_E, busy);
      chk("rnd_flush_D", hif.flush_D, fd);
      chk("rnd_flush_E", hif.flush_E, fe);
      chk("rnd_mem_busy", hif.mem_busy, busy);
      chk("rnd_stall_cnt", hif.stall_cnt, m_sc);
      chk("rnd_flush_cnt", hif.flush_cnt, m_fc);
      tick();
      if (sf) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
      if (fd || fe) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_ign = 1;
      end else if (m_ign) begin
        m_ign = 0;
      end else if (hif.memAccess_M) begin
        m_left = MEM_LAT - 1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
